// File: rtl/run_ctrl_pkg.sv
// Shared definitions for the core run controller: FSM state encoding and run modes.
package run_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_HALT  = 2'd3
   } state_e;

   localparam logic [1:0] MODE_FREE   = 2'd0;
   localparam logic [1:0] MODE_BUDGET = 2'd1;
   localparam logic [1:0] MODE_SSTEP  = 2'd2;

   // Mode 3 falls back to free-run, so only single-step selects STEP.
   function automatic state_e entry_state(input logic [1:0] mode);
      return (mode == MODE_SSTEP) ? ST_STEP : ST_RUN;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// One-bit switch debouncer: 2-flop synchroniser, stability counter, registered output.
module sw_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter logic        RST_VAL         = 1'b1
) (
   input  logic iClk,
   input  logic iRst,
   input  logic iRaw,
   output logic oSw
);

   localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_out;
   logic [CNT_W-1:0] r_cnt;

   // A change is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_sync1  <= RST_VAL;
         r_sync2  <= RST_VAL;
         r_stable <= RST_VAL;
         r_out    <= RST_VAL;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= iRaw;
         r_sync2 <= r_sync1;
         r_out   <= r_stable;
         if (r_sync2 != r_stable) begin
            if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_stable <= r_sync2;
               r_cnt    <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign oSw = r_out;

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle core: reset pulse, clock-enable modes,
// saturating cycle counter and debounced switches.
module core_run_ctrl
   import run_ctrl_pkg::*;
#(
   parameter int unsigned          SW_WIDTH        = 8,
   parameter logic [SW_WIDTH-1:0]  SW_RESET        = '1,
   parameter int unsigned          RST_CYCLES      = 2,
   parameter int unsigned          DEBOUNCE_CYCLES = 4,
   parameter int unsigned          CNT_WIDTH       = 16,
   parameter int unsigned          MAX_CYCLES      = 1250
) (
   input  logic                 iClk,
   input  logic                 iRst,
   input  logic [1:0]           iMode,
   input  logic                 iStep,
   input  logic                 iHaltReq,
   input  logic                 iResume,
   input  logic [SW_WIDTH-1:0]  iSwitch,
   output logic                 oCoreRst_n,
   output logic                 oCoreEn,
   output logic [CNT_WIDTH-1:0] oCycles,
   output logic [1:0]           oState,
   output logic                 oHalted,
   output logic                 oLimitHit,
   output logic [SW_WIDTH-1:0]  oSwitch
);

   localparam int unsigned HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_e               r_state;
   state_e               w_state_nxt;
   logic [HOLD_W-1:0]    r_hold,    w_hold_nxt;
   logic [CNT_WIDTH-1:0] r_budget,  w_budget_nxt;
   logic [CNT_WIDTH-1:0] r_cycles,  w_cycles_nxt;
   logic                 r_bmode,   w_bmode_nxt;
   logic                 r_en,      w_en_nxt;
   logic                 r_rst_n,   w_rst_n_nxt;
   logic                 r_limit,   w_limit_nxt;
   logic                 r_halted,  w_halted_nxt;
   logic                 r_step_pend, w_step_pend_nxt;
   logic                 r_halt_q;
   logic                 r_step_hist;

   logic w_hold_done;
   logic w_budget_last;
   logic w_resume;
   logic w_load;

   assign w_hold_done   = (r_hold == HOLD_W'(RST_CYCLES - 1));
   assign w_budget_last = r_bmode && (r_budget == CNT_WIDTH'(1));
   assign w_resume      = iResume && !iHaltReq;
   assign w_load        = ((r_state == ST_RESET) && w_hold_done) ||
                          ((r_state == ST_HALT) && w_resume);

   always_ff @(posedge iClk) begin
      if (iRst) r_state <= ST_RESET;
      else      r_state <= w_state_nxt;
   end

   // Halt acts on the registered request, leaving the core one in-flight cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RESET: if (w_hold_done)                w_state_nxt = entry_state(iMode);
         ST_RUN:   if (r_halt_q || w_budget_last)  w_state_nxt = ST_HALT;
         ST_STEP:  if (r_halt_q)                   w_state_nxt = ST_HALT;
         ST_HALT:  if (w_resume)                   w_state_nxt = entry_state(iMode);
         default:                                  w_state_nxt = ST_RESET;
      endcase
   end

   always_comb begin
      w_hold_nxt      = r_hold;
      w_budget_nxt    = r_budget;
      w_bmode_nxt     = r_bmode;
      w_limit_nxt     = r_limit;
      w_cycles_nxt    = r_cycles;
      w_rst_n_nxt     = (w_state_nxt != ST_RESET);
      w_halted_nxt    = (w_state_nxt == ST_HALT);
      w_en_nxt        = (w_state_nxt == ST_RUN) ||
                        ((r_state == ST_STEP) && (w_state_nxt == ST_STEP) && r_step_pend);
      w_step_pend_nxt = (r_state == ST_STEP) && iStep && !r_step_hist;

      if ((r_state == ST_RESET) && !w_hold_done) w_hold_nxt = r_hold + HOLD_W'(1);
      if (r_en && (r_cycles != '1))              w_cycles_nxt = r_cycles + CNT_WIDTH'(1);

      if (w_load) begin
         w_budget_nxt = CNT_WIDTH'(MAX_CYCLES);
         w_bmode_nxt  = (iMode == MODE_BUDGET);
      end else if ((r_state == ST_RUN) && r_bmode) begin
         w_budget_nxt = r_budget - CNT_WIDTH'(1);
      end

      if ((r_state == ST_RUN) && w_budget_last)  w_limit_nxt = 1'b1;
      if ((r_state == ST_HALT) && w_resume)      w_limit_nxt = 1'b0;
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         r_hold      <= '0;
         r_budget    <= CNT_WIDTH'(MAX_CYCLES);
         r_bmode     <= 1'b0;
         r_cycles    <= '0;
         r_en        <= 1'b0;
         r_rst_n     <= 1'b0;
         r_limit     <= 1'b0;
         r_halted    <= 1'b0;
         r_step_pend <= 1'b0;
         r_halt_q    <= 1'b0;
         r_step_hist <= 1'b1;
      end else begin
         r_hold      <= w_hold_nxt;
         r_budget    <= w_budget_nxt;
         r_bmode     <= w_bmode_nxt;
         r_cycles    <= w_cycles_nxt;
         r_en        <= w_en_nxt;
         r_rst_n     <= w_rst_n_nxt;
         r_limit     <= w_limit_nxt;
         r_halted    <= w_halted_nxt;
         r_step_pend <= w_step_pend_nxt;
         r_halt_q    <= iHaltReq;
         r_step_hist <= iStep;
      end
   end

   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_deb
      sw_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RST_VAL         (SW_RESET[g])
      ) u_deb (
         .iClk (iClk),
         .iRst (iRst),
         .iRaw (iSwitch[g]),
         .oSw  (oSwitch[g])
      );
   end

   assign oCoreRst_n = r_rst_n;
   assign oCoreEn    = r_en;
   assign oCycles    = r_cycles;
   assign oState     = r_state;
   assign oHalted    = r_halted;
   assign oLimitHit  = r_limit;

endmodule
